// File: rtl/multicycle_ctrl_v2.sv
// Multicycle RV32I-subset control unit: Moore FSM sequencing PC/IR/A/B/ALUOut/MDR,
// the register file and the datapath muxes, with a parametrised memory wait counter.
module multicycle_ctrl_v2 #(
  parameter int MEM_LATENCY = 0,
  parameter bit EN_JUMP     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  output logic        pc_write,
  output logic        ir_load,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_a_load,
  output logic        reg_b_load,
  output logic        alu_out_load,
  output logic        mdr_load,
  output logic        reg_write,
  output logic [2:0]  alu_op,
  output logic [1:0]  sel_alu_a,
  output logic [1:0]  sel_alu_b,
  output logic [1:0]  sel_wb,
  output logic [1:0]  sel_pc,
  output logic        halted,
  output logic [3:0]  state_out
);

  localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY);

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_LUI    = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_JALR   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          mem_state;
  logic [6:0]    opcode;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic          r_legal;
  logic [2:0]    r_op;
  logic          unused_instr;

  assign opcode       = instr[6:0];
  assign f3           = instr[14:12];
  assign f7           = instr[31:25];
  assign unused_instr = ^{instr[24:15], instr[11:7]};
  assign cnt_last     = (cnt == CNT_LAST);
  assign mem_state    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign state_out    = state;

  // R-type function decode; unsupported f7/f3 pairs trap to HALT
  always_comb begin
    r_legal = 1'b1;
    r_op    = ALU_ADD;
    if (f7 == 7'b0000000) begin
      case (f3)
        3'b000:  r_op = ALU_ADD;
        3'b111:  r_op = ALU_AND;
        3'b110:  r_op = ALU_OR;
        3'b100:  r_op = ALU_XOR;
        3'b010:  r_op = ALU_SLT;
        default: r_legal = 1'b0;
      endcase
    end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
      r_op = ALU_SUB;
    end else begin
      r_legal = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        cnt <= '0;
      else if (mem_state && !cnt_last)
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (cnt_last) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:      next_state = S_EXEC_R;
          OP_I:      next_state = S_EXEC_I;
          OP_LOAD:   next_state = S_ADDR;
          OP_STORE:  next_state = S_ADDR;
          OP_BRANCH: next_state = S_BRANCH;
          OP_LUI:    next_state = S_LUI;
          OP_JAL:    next_state = EN_JUMP ? S_JAL : S_HALT;
          OP_JALR:   next_state = EN_JUMP ? S_JALR : S_HALT;
          default:   next_state = S_HALT;
        endcase
      end
      S_EXEC_R: next_state = r_legal ? S_WB_ALU : S_HALT;
      S_EXEC_I: next_state = S_WB_ALU;
      S_ADDR:   next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (cnt_last) next_state = S_WB_MEM;
      S_MEM_WR: if (cnt_last) next_state = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_LUI, S_JAL, S_JALR: next_state = S_FETCH;
      S_BRANCH: next_state = (f3 == 3'b000 || f3 == 3'b001) ? S_FETCH : S_HALT;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    ir_load      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_a_load   = 1'b0;
    reg_b_load   = 1'b0;
    alu_out_load = 1'b0;
    mdr_load     = 1'b0;
    reg_write    = 1'b0;
    alu_op       = ALU_ADD;
    sel_alu_a    = 2'd0;
    sel_alu_b    = 2'd0;
    sel_wb       = 2'd0;
    sel_pc       = 2'd0;
    halted       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        sel_alu_b = 2'd1;
        if (cnt_last) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        reg_a_load   = 1'b1;
        reg_b_load   = 1'b1;
        alu_out_load = 1'b1;
        sel_alu_a    = 2'd2;
        sel_alu_b    = 2'd2;
      end
      S_EXEC_R: begin
        sel_alu_a    = 2'd1;
        alu_out_load = 1'b1;
        alu_op       = r_op;
      end
      S_EXEC_I, S_ADDR: begin
        sel_alu_a    = 2'd1;
        sel_alu_b    = 2'd2;
        alu_out_load = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        mdr_load = cnt_last;
      end
      S_MEM_WR: mem_write = 1'b1;
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write = 1'b1;
        sel_wb    = 2'd1;
      end
      S_LUI: begin
        reg_write = 1'b1;
        sel_wb    = 2'd2;
      end
      // only output that is not a pure function of the state
      S_BRANCH: begin
        alu_op    = ALU_SUB;
        sel_alu_a = 2'd1;
        sel_pc    = 2'd1;
        pc_write  = (f3 == 3'b000 && alu_zero) || (f3 == 3'b001 && !alu_zero);
      end
      S_JAL: begin
        pc_write  = 1'b1;
        sel_pc    = 2'd1;
        reg_write = 1'b1;
        sel_wb    = 2'd3;
      end
      S_JALR: begin
        sel_alu_a = 2'd1;
        sel_alu_b = 2'd2;
        sel_pc    = 2'd2;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        sel_wb    = 2'd3;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
    // enables must be quiet for the whole time reset is held, not just after the edge
    if (!rst) begin
      pc_write     = 1'b0;
      ir_load      = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_a_load   = 1'b0;
      reg_b_load   = 1'b0;
      alu_out_load = 1'b0;
      mdr_load     = 1'b0;
      reg_write    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: one unit at latency 0 with jumps, one at latency 3
// without jumps, checked cycle by cycle against per-instruction control sequences.
module tb_multicycle_ctrl_v2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_load;
    logic       mem_read;
    logic       mem_write;
    logic       reg_a_load;
    logic       reg_b_load;
    logic       alu_out_load;
    logic       mdr_load;
    logic       reg_write;
    logic [2:0] alu_op;
    logic [1:0] sel_alu_a;
    logic [1:0] sel_alu_b;
    logic [1:0] sel_wb;
    logic [1:0] sel_pc;
    logic       halted;
  } ctl_t;

  localparam logic [2:0] OP_ADD = 3'b001, OP_SUB = 3'b010, OP_AND = 3'b011,
                         OP_OR  = 3'b100, OP_XOR = 3'b101, OP_SLT = 3'b110;
  localparam logic [20:0] ALL_MASK = 21'h1FFFFF;
  localparam logic [20:0] EN_MASK  = 21'b1_1_1_1_1_1_1_1_1_000_00_00_00_00_1;
  localparam int LAT_B     = 3;
  localparam int HALT_HOLD = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, zero_a, zero_b;
  logic [31:0] instr_a, instr_b;
  logic [3:0]  state_a, state_b;
  ctl_t        act_a, act_b, exp_a, exp_b;
  logic        pcw_a, irl_a, mrd_a, mwr_a, ral_a, rbl_a, aol_a, mdl_a, rw_a, hlt_a;
  logic        pcw_b, irl_b, mrd_b, mwr_b, ral_b, rbl_b, aol_b, mdl_b, rw_b, hlt_b;
  logic [2:0]  aop_a, aop_b;
  logic [1:0]  sa_a, sb_a, swb_a, spc_a, sa_b, sb_b, swb_b, spc_b;

  int    checks = 0;
  int    errors = 0;
  ctl_t  q_a[$], q_b[$], model_q[$];
  string tag_a = "", tag_b = "";
  int    step_a = 0, step_b = 0;

  multicycle_ctrl_v2 #(.MEM_LATENCY(0), .EN_JUMP(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .instr(instr_a), .alu_zero(zero_a),
    .pc_write(pcw_a), .ir_load(irl_a), .mem_read(mrd_a), .mem_write(mwr_a),
    .reg_a_load(ral_a), .reg_b_load(rbl_a), .alu_out_load(aol_a), .mdr_load(mdl_a),
    .reg_write(rw_a), .alu_op(aop_a), .sel_alu_a(sa_a), .sel_alu_b(sb_a),
    .sel_wb(swb_a), .sel_pc(spc_a), .halted(hlt_a), .state_out(state_a)
  );

  multicycle_ctrl_v2 #(.MEM_LATENCY(LAT_B), .EN_JUMP(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .instr(instr_b), .alu_zero(zero_b),
    .pc_write(pcw_b), .ir_load(irl_b), .mem_read(mrd_b), .mem_write(mwr_b),
    .reg_a_load(ral_b), .reg_b_load(rbl_b), .alu_out_load(aol_b), .mdr_load(mdl_b),
    .reg_write(rw_b), .alu_op(aop_b), .sel_alu_a(sa_b), .sel_alu_b(sb_b),
    .sel_wb(swb_b), .sel_pc(spc_b), .halted(hlt_b), .state_out(state_b)
  );

  assign act_a = {pcw_a, irl_a, mrd_a, mwr_a, ral_a, rbl_a, aol_a, mdl_a, rw_a,
                  aop_a, sa_a, sb_a, swb_a, spc_a, hlt_a};
  assign act_b = {pcw_b, irl_b, mrd_b, mwr_b, ral_b, rbl_b, aol_b, mdl_b, rw_b,
                  aop_b, sa_b, sb_b, swb_b, spc_b, hlt_b};

  function automatic ctl_t idle();
    ctl_t c;
    c        = '0;
    c.alu_op = OP_ADD;
    return c;
  endfunction

  function automatic void push_halt();
    ctl_t c;
    for (int i = 0; i < HALT_HOLD; i++) begin
      c        = idle();
      c.halted = 1'b1;
      model_q.push_back(c);
    end
  endfunction

  // Expected per-cycle control words for one instruction, from the instruction's class
  function automatic void buildModel(input logic [31:0] ins, input logic zero,
                                     input int lat, input bit enj);
    ctl_t       c;
    logic [6:0] opc, f7;
    logic [2:0] f3, rop;
    bit         legal;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    model_q.delete();
    for (int i = 0; i <= lat; i++) begin
      c = idle(); c.mem_read = 1'b1; c.sel_alu_b = 2'd1;
      if (i == lat) begin c.ir_load = 1'b1; c.pc_write = 1'b1; end
      model_q.push_back(c);
    end
    c = idle(); c.reg_a_load = 1'b1; c.reg_b_load = 1'b1; c.alu_out_load = 1'b1;
    c.sel_alu_a = 2'd2; c.sel_alu_b = 2'd2;
    model_q.push_back(c);
    case (opc)
      7'b0110011: begin
        legal = 1'b1;
        rop   = OP_ADD;
        case ({f7, f3})
          10'b0000000_000: rop = OP_ADD;
          10'b0100000_000: rop = OP_SUB;
          10'b0000000_111: rop = OP_AND;
          10'b0000000_110: rop = OP_OR;
          10'b0000000_100: rop = OP_XOR;
          10'b0000000_010: rop = OP_SLT;
          default:         legal = 1'b0;
        endcase
        c = idle(); c.sel_alu_a = 2'd1; c.alu_out_load = 1'b1; c.alu_op = rop;
        model_q.push_back(c);
        if (legal) begin c = idle(); c.reg_write = 1'b1; model_q.push_back(c); end
        else push_halt();
      end
      7'b0010011: begin
        c = idle(); c.sel_alu_a = 2'd1; c.sel_alu_b = 2'd2; c.alu_out_load = 1'b1;
        model_q.push_back(c);
        c = idle(); c.reg_write = 1'b1; model_q.push_back(c);
      end
      7'b0000011, 7'b0100011: begin
        c = idle(); c.sel_alu_a = 2'd1; c.sel_alu_b = 2'd2; c.alu_out_load = 1'b1;
        model_q.push_back(c);
        for (int i = 0; i <= lat; i++) begin
          c = idle();
          if (opc == 7'b0000011) begin c.mem_read = 1'b1; c.mdr_load = (i == lat); end
          else c.mem_write = 1'b1;
          model_q.push_back(c);
        end
        if (opc == 7'b0000011) begin
          c = idle(); c.reg_write = 1'b1; c.sel_wb = 2'd1; model_q.push_back(c);
        end
      end
      7'b1100011: begin
        c = idle(); c.alu_op = OP_SUB; c.sel_alu_a = 2'd1; c.sel_pc = 2'd1;
        c.pc_write = (f3 == 3'b000) ? zero : ((f3 == 3'b001) ? !zero : 1'b0);
        model_q.push_back(c);
        if (f3 != 3'b000 && f3 != 3'b001) push_halt();
      end
      7'b0110111: begin
        c = idle(); c.reg_write = 1'b1; c.sel_wb = 2'd2; model_q.push_back(c);
      end
      7'b1101111: begin
        if (enj) begin
          c = idle(); c.pc_write = 1'b1; c.sel_pc = 2'd1; c.reg_write = 1'b1; c.sel_wb = 2'd3;
          model_q.push_back(c);
        end else push_halt();
      end
      7'b1100111: begin
        if (enj) begin
          c = idle(); c.sel_alu_a = 2'd1; c.sel_alu_b = 2'd2; c.sel_pc = 2'd2;
          c.pc_write = 1'b1; c.reg_write = 1'b1; c.sel_wb = 2'd3;
          model_q.push_back(c);
        end else push_halt();
      end
      default: push_halt();
    endcase
  endfunction

  task automatic checkOutput(input string name, input ctl_t act, input ctl_t exp,
                             input logic [20:0] mask);
    logic [20:0] a, e;
    a = act;
    e = exp;
    checks++;
    if ((a & mask) !== (e & mask)) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b (mask %b)", name, a, e, mask);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // The compare process: one expected word per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      exp_a = q_a.pop_front();
      checkOutput($sformatf("A %s cycle%0d", tag_a, step_a), act_a, exp_a, ALL_MASK);
      step_a++;
    end
    if (q_b.size() > 0) begin
      exp_b = q_b.pop_front();
      checkOutput($sformatf("B %s cycle%0d", tag_b, step_b), act_b, exp_b, ALL_MASK);
      step_b++;
    end
  end

  task automatic launch(input bit sel, input logic [31:0] ins, input logic zero,
                        input string tag);
    @(posedge clk);
    #1;
    if (!sel) begin
      buildModel(ins, zero, 0, 1'b1);
      instr_a = ins; zero_a = zero; rst_a = 1'b1; tag_a = tag; step_a = 0;
      foreach (model_q[i]) q_a.push_back(model_q[i]);
    end else begin
      buildModel(ins, zero, LAT_B, 1'b0);
      instr_b = ins; zero_b = zero; rst_b = 1'b1; tag_b = tag; step_b = 0;
      foreach (model_q[i]) q_b.push_back(model_q[i]);
    end
  endtask

  task automatic waitQueue(input bit sel, input int left);
    int budget;
    budget = 0;
    while ((sel ? q_b.size() : q_a.size()) > left && budget < 300) begin
      @(negedge clk);
      #2;
      budget++;
    end
    if ((sel ? q_b.size() : q_a.size()) > left) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout on unit %0d: %0d cycles left, required <= %0d",
               sel, sel ? q_b.size() : q_a.size(), left);
      if (sel) q_b.delete(); else q_a.delete();
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic [31:0] ins, input logic zero,
                               input string tag);
    launch(sel, ins, zero, tag);
    waitQueue(sel, 0);
  endtask

  task automatic resetPulse(input bit sel, input string name);
    @(posedge clk);
    #1;
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    #1;
    checkOutput(name, sel ? act_b : act_a, '0, EN_MASK);
  endtask

  logic [31:0] vec_ins [15] = '{32'h00000033, 32'h40000033, 32'h00007033, 32'h00006033,
                                32'h00004033, 32'h00002033, 32'h00000013, 32'h00000037,
                                32'h00000063, 32'h00001063, 32'h00001063, 32'h0000006F,
                                32'h00000067, 32'h00000023, 32'h00000003};
  logic        vec_zero [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  string       vec_tag [15]  = '{"ADD", "SUB", "AND", "OR", "XOR", "SLT", "ADDI", "LUI",
                                 "BEQ_taken", "BNE_zero", "BNE_nonzero", "JAL", "JALR",
                                 "SW", "LW"};
  logic [31:0] halt_ins [4]  = '{32'h40007033, 32'h00004063, 32'h0000007F, 32'h00001033};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    instr_a = '0; instr_b = '0; zero_a = 1'b0; zero_b = 1'b0;
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // hand-computed pins on the model itself
    buildModel(32'h00000033, 1'b0, 0, 1'b1);
    checkInt("model R length L0", model_q.size(), 4);
    buildModel(32'h00000037, 1'b0, 0, 1'b1);
    checkInt("model LUI length L0", model_q.size(), 3);
    buildModel(32'h00000003, 1'b0, 3, 1'b1);
    checkInt("model LW length L3", model_q.size(), 11);
    checkOutput("model LW last MEM_RD word", model_q[9],
                21'b0_0_1_0_0_0_0_1_0_001_00_00_00_00_0, ALL_MASK);
    buildModel(32'h00000023, 1'b0, 3, 1'b1);
    checkInt("model SW length L3", model_q.size(), 10);
    buildModel(32'h00000063, 1'b1, 3, 1'b1);
    checkInt("model BEQ length L3", model_q.size(), 6);
    buildModel(32'h0000006F, 1'b0, 0, 1'b1);
    checkInt("model JAL length L0", model_q.size(), 3);
    checkOutput("model JAL word", model_q[2],
                21'b1_0_0_0_0_0_0_0_1_001_00_00_11_01_0, ALL_MASK);

    @(negedge clk);
    checkOutput("reset A", act_a, '0, EN_MASK);
    checkOutput("reset B", act_b, '0, EN_MASK);

    for (int i = 0; i < 15; i++) applyStimulus(1'b0, vec_ins[i], vec_zero[i], vec_tag[i]);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, halt_ins[i], 1'b0, $sformatf("illegal%0d", i));
      resetPulse(1'b0, $sformatf("A reset out of HALT %0d", i));
    end
    applyStimulus(1'b0, 32'h00000033, 1'b0, "ADD_after_halt");
    rst_a = 1'b0;

    applyStimulus(1'b1, 32'h00000003, 1'b0, "LW");
    applyStimulus(1'b1, 32'h00000023, 1'b0, "SW");
    applyStimulus(1'b1, 32'h00000033, 1'b0, "ADD");
    applyStimulus(1'b1, 32'h00000063, 1'b0, "BEQ_nonzero");
    applyStimulus(1'b1, 32'h0000006F, 1'b0, "JAL_disabled");
    resetPulse(1'b1, "B reset out of HALT jal");
    applyStimulus(1'b1, 32'h00000067, 1'b0, "JALR_disabled");
    resetPulse(1'b1, "B reset out of HALT jalr");

    // reset in the middle of MEM_RD with the wait counter already running
    launch(1'b1, 32'h00000003, 1'b0, "LW_interrupted");
    waitQueue(1'b1, 3);
    rst_b = 1'b0;
    #1;
    checkOutput("B mid-access reset", act_b, '0, EN_MASK);
    q_b.delete();
    applyStimulus(1'b1, 32'h00000033, 1'b0, "ADD_after_midreset");
    rst_b = 1'b0;

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_v2.md
# multicycle_ctrl_v2

Parametrised multicycle control unit for the RV32I-subset datapath; successor to the current fixed-sequence controller. It decodes `instr` and sequences the following datapath elements through a Moore FSM:

- PC, IR, A/B, ALUOut and MDR registers
- register file
- ALU/PC/writeback multiplexers

New over the previous generation: full R-type ALU decode, a parametrised memory latency counter, optional JAL/JALR, and a sticky illegal-instruction halt.

## Interface
- `MEM_LATENCY`, 0, extra wait cycles per memory access (0..15).
- `EN_JUMP`, 1, 1 = JAL/JALR supported; 0 = their opcodes are illegal.
- `clk` in 1 system clock, rising edge.
- `rst` in 1 reset, asynchronous, active-low.
- `instr` in 32 IR contents.
- `alu_zero` in 1 ALU result == 0.
- `pc_write`, `ir_load`, `mem_read`, `mem_write`, `reg_a_load`, `reg_b_load`, `alu_out_load`, `mdr_load`, `reg_write`: out, 1 bit each, datapath enables.
- `alu_op` out 3: 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SLT.
- `sel_alu_a` out 2: 0 PC, 1 A, 2 oldPC.
- `sel_alu_b` out 2: 0 B, 1 const 4, 2 imm.
- `sel_wb` out 2: 0 ALUOut, 1 MDR, 2 imm (LUI), 3 PC.
- `sel_pc` out 2: 0 ALU result, 1 ALUOut, 2 ALU result & ~1.
- `halted` out 1: illegal instruction trapped.
- `state_out` out 4: current state encoding, for debug.

## Operation
- Control outputs are combinational from the state, with one exception: `pc_write` in BRANCH. Any enable not listed for a state is 0.
- Default selects: all 0, `alu_op`=ADD.
- Reset (`rst`=0), asynchronous:
  - state=FETCH, wait counter=0, `halted`=0.
  - All enables are 0 while `rst` is low.
- FETCH:
  - `mem_read`=1, ALU computes PC+4 (`sel_alu_a`=0, `sel_alu_b`=1).
  - The counter runs 0..MEM_LATENCY.
  - On the final cycle (counter==MEM_LATENCY): `ir_load`=`pc_write`=1, `sel_pc`=0, then go to DECODE.
- DECODE:
  - `reg_a_load`=`reg_b_load`=`alu_out_load`=1.
  - ALU computes oldPC+imm (`sel_alu_a`=2, `sel_alu_b`=2) as the branch/JAL target.
  - Next state by opcode: 0110011→EXEC_R; 0010011→EXEC_I; 0000011/0100011→ADDR; 1100011→BRANCH; 0110111→LUI; 1101111→JAL; 1100111→JALR; anything else→HALT.
  - If EN_JUMP=0, JAL and JALR opcodes go to HALT.
- EXEC_R:
  - `sel_alu_a`=1, `sel_alu_b`=0, `alu_out_load`=1.
  - f7=0000000: f3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT.
  - f7=0100000 with f3=000: SUB.
  - Any other combination → HALT instead of WB_ALU.
- EXEC_I: ADD A+imm, `alu_out_load`=1 → WB_ALU.
- ADDR: ADD A+imm, `alu_out_load`=1 → MEM_RD for a load, MEM_WR for a store.
- MEM_RD:
  - `mem_read`=1, counter runs as in FETCH.
  - Final cycle: `mdr_load`=1 → WB_MEM.
- MEM_WR: `mem_write`=1 held for MEM_LATENCY+1 cycles → FETCH.
- WB_ALU: `reg_write`=1, `sel_wb`=0 → FETCH.
- WB_MEM: `reg_write`=1, `sel_wb`=1 → FETCH.
- LUI: `reg_write`=1, `sel_wb`=2 → FETCH.
- BRANCH:
  - SUB A−B, `sel_pc`=1.
  - `pc_write` = (f3==000 & `alu_zero`) | (f3==001 & !`alu_zero`).
  - Other f3 → HALT, with `pc_write`=0.
  - Otherwise → FETCH.
- JAL: `pc_write`=1, `sel_pc`=1, `reg_write`=1, `sel_wb`=3 → FETCH. The register file captures PC (oldPC+4) before the same edge updates PC.
- JALR: ADD A+imm, `sel_pc`=2, `pc_write`=1, `reg_write`=1, `sel_wb`=3 → FETCH.
- HALT:
  - `halted`=1, all enables 0.
  - Absorbing: only `rst` exits it.
- Counter:
  - Width max(1, clog2(MEM_LATENCY+1)).
  - Cleared on every state change and by reset.
  - Never wraps: it holds the state until it reaches MEM_LATENCY.

## Timing
- Cycles per instruction, with L=MEM_LATENCY: R/I-ALU 4+L; LUI 3+L; load 5+2L; store 4+2L; branch 3+L; JAL/JALR 3+L.
- Reset asserted mid-access (e.g. MEM_RD, counter>0): outputs drop to 0 immediately; the first cycle after release is FETCH with counter 0.
- Only `pc_write` in BRANCH depends on `alu_zero`, and it must be settled before the clock edge.

## Test plan
- Reset then ADD (f7=0, f3=000, opcode 0110011), L=0 → states FETCH, DECODE, EXEC_R, WB_ALU, FETCH. `reg_write`=1 only in cycle 4 with `sel_wb`=0.
- L=3, load word → `mem_read` high 4 cycles in FETCH and 4 in MEM_RD. `mdr_load` pulses only on the 4th MEM_RD cycle. Total 11 cycles.
- BEQ with `alu_zero`=1 → `pc_write`=1, `sel_pc`=1. BNE with `alu_zero`=1 → `pc_write`=0. Both return to FETCH.
- EN_JUMP=0, opcode 1101111 → HALT, `halted`=1 and holds for 20 cycles. `rst` pulse → FETCH, `halted`=0.
- JAL → in the JAL state, `pc_write`=`reg_write`=1 together, `sel_wb`=3, `sel_pc`=1. Next state FETCH.
- R-type f7=0100000, f3=111 → HALT after EXEC_R; `reg_write` never asserted.
